// File: rtl/mult_seq.sv
// Iterative shift-add multiplier for MULT/MULTU: one product bit per cycle,
// signed operands are reduced to magnitudes and the sign is reapplied in FIX.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   acc;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // acc holds the upper product half; mag_b shifts out multiplier bits and
  // shifts in finished low product bits, so {acc,mag_b} is the product after WIDTH steps.
  always_comb begin
    sum  = {1'b0, acc} + (mag_b[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    prod = {acc, mag_b};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // |-2^(W-1)| wraps to itself, which is the correct unsigned magnitude
          mag_a <= (is_signed && a[WIDTH-1]) ? -a : a;
          mag_b <= (is_signed && b[WIDTH-1]) ? -b : b;
          neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc   <= sum[WIDTH:1];
          mag_b <= {sum[0], mag_b[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= neg ? -prod : prod;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: stimulus pushes expected {hi,lo}, a negedge
// monitor pops and compares on every done pulse.
module tb_mult_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad = 0;
  int mon_total = 0;
  int mon_bad = 0;
  logic [2*W-1:0] exp_q[$];

  mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        mon_total++;
        if (exp_q.size() == 0) begin
          mon_bad++;
          $display("FAIL unexpected_done: got hi=%h lo=%h, required no done", hi, lo);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          if ({hi, lo} !== e) begin
            mon_bad++;
            $display("FAIL product: got hi=%h lo=%h, required hi=%h lo=%h",
                     hi, lo, e[2*W-1:W], e[W-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Present an operation; start is sampled at the next rising edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s,
                       input logic [2*W-1:0] e, input bit push);
    start = 1'b1; a = ia; b = ib; is_signed = s;
    if (push) exp_q.push_back(e);
  endtask

  // Consume the start edge, then wait for done. lat counts edges from the
  // start edge up to the FIX edge inclusive; glitch pulses a stray start mid-RUN.
  task automatic wait_done(output int lat, output int bcnt, input bit glitch);
    lat = 0; bcnt = 0;
    @(posedge clk); #1;
    lat = 1;
    if (busy) bcnt++;
    start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    while (!done && lat < 100) begin
      if (glitch && lat == 5) begin start = 1'b1; a = 9; b = 9; is_signed = 1'b1; end
      @(posedge clk); #1;
      lat++;
      if (glitch && lat == 6) begin start = 1'b0; a = '0; b = '0; end
      if (busy) bcnt++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: got no done after %0d cycles, required done", lat);
    end
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s,
                    input logic [2*W-1:0] e, input string name);
    int lat, bcnt;
    issue(ia, ib, s, e, 1'b1);
    wait_done(lat, bcnt, 1'b0);
    check({name, "_latency"}, 64'(lat), 64'd34);
  endtask

  initial begin
    int lat, bcnt;
    logic seen;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 3*5 unsigned: busy 33 cycles, done visible 34 cycles after start edge
    issue(32'd3, 32'd5, 1'b0, 64'd15, 1'b1);
    wait_done(lat, bcnt, 1'b0);
    check("t1_busy_cycles", 64'(bcnt), 64'd33);
    check("t1_latency", 64'(lat), 64'd34);
    check("t1_busy_in_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("t1_done_one_cycle", 64'(done), 64'd0);

    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "t2_multu_max");
    op(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, "t3_neg7x6");
    op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'd42, "t3_neg7xneg6");
    op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "t4_mult_min");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "t4_multu_min");
    op(32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0, "zero_signed");
    op(32'hFFFF_FFFF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "neg1x1");

    // stray start during RUN is ignored
    issue(32'd100, 32'd7, 1'b0, 64'd700, 1'b1);
    wait_done(lat, bcnt, 1'b1);
    check("t5_glitch_latency", 64'(lat), 64'd34);
    // start held in the done cycle is accepted at the edge ending it
    issue(32'd12, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFDC, 1'b1);
    wait_done(lat, bcnt, 1'b0);
    check("t5_b2b_latency", 64'(lat), 64'd34);
    @(posedge clk); #1;

    // reset at RUN cycle 10 aborts: no done, outputs cleared
    issue(32'd1234, 32'd5678, 1'b0, 64'd0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("t6_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_hi", 64'(hi), 64'd0);
    check("t6_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("t6_no_done_after_abort", 64'(seen), 64'd0);
    op(32'd2, 32'd2, 1'b0, 64'd4, "t6_after_reset");

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    total += mon_total;
    bad += mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end
endmodule
